hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard control (scoreboard-based stall/forward selection plus mult/div busy tracking).
// Latency : stall, fwd_rs and fwd_rt are combinational; md_busy rises the cycle after a mult/div start.
// Backpressure: stall freezes PC/D and injects a bubble into E; the scoreboard and md counter never freeze.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   d_rs, d_rt             D-stage source register numbers
//   d_use_rs, d_use_rt     D instruction actually reads rs / rt
//   d_tuse_rs, d_tuse_rt   cycles until each operand is needed (0..2)
//   d_a3, d_regwrite       D-stage destination register and write enable
//   d_tnew                 cycles after entering E until the result exists
//   d_md                   D instruction needs the mult/div unit
//   e_md_start             01 mult start, 10 div start, 00/11 none
//   stall                  hazard detected for the D instruction
//   fwd_rs, fwd_rt         0 = register file, k+1 = forward from tracked stage k
//   md_busy                mult/div unit busy
module hazard_ctrl #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int FW      = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic [1:0]    d_tuse_rs,
    input  logic [1:0]    d_tuse_rt,
    input  logic [4:0]    d_a3,
    input  logic          d_regwrite,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md,
    input  logic [1:0]    e_md_start,
    output logic          stall,
    output logic [FW-1:0] fwd_rs,
    output logic [FW-1:0] fwd_rt,
    output logic          md_busy
);

    localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    // Scoreboard: entry 0 is the instruction currently in E, entry k is k stages further on.
    logic          sb_vld  [NSTAGE];
    logic [4:0]    sb_a3   [NSTAGE];
    logic [TW-1:0] sb_tnew [NSTAGE];

    logic [NSTAGE-1:0] live;
    logic              rs_hazard;
    logic              rt_hazard;
    logic              md_hazard;
    logic              md_start_vld;
    logic [CW-1:0]     md_cnt;

    // ------------------------------------------------------------------
    // Scoreboard shift; tnew counts down toward 0 as the entry ages.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_vld[k]  <= 1'b0;
                sb_a3[k]   <= 5'd0;
                sb_tnew[k] <= '0;
            end
        end else begin
            if (stall) begin
                sb_vld[0]  <= 1'b0;
                sb_a3[0]   <= 5'd0;
                sb_tnew[0] <= '0;
            end else begin
                sb_vld[0]  <= d_regwrite;
                sb_a3[0]   <= d_a3;
                sb_tnew[0] <= d_tnew;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                sb_vld[k]  <= sb_vld[k-1];
                sb_a3[k]   <= sb_a3[k-1];
                sb_tnew[k] <= (sb_tnew[k-1] != '0) ? sb_tnew[k-1] - 1'b1 : '0;
            end
        end
    end

    always_comb begin
        live = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            live[k] = sb_vld[k] && (sb_a3[k] != 5'd0);
        end
    end

    // ------------------------------------------------------------------
    // Operand hazards and forward selection. The loop runs oldest to
    // youngest so the youngest matching entry decides the forward select;
    // a young match whose result is not ready blocks forwarding from any
    // older copy of the same register.
    // ------------------------------------------------------------------
    always_comb begin
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        fwd_rs    = '0;
        fwd_rt    = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (d_use_rs && (d_rs != 5'd0) && live[k] && (sb_a3[k] == d_rs)) begin
                if (32'(sb_tnew[k]) > 32'(d_tuse_rs)) begin
                    rs_hazard = 1'b1;
                end
                fwd_rs = (sb_tnew[k] == '0) ? FW'(k + 1) : '0;
            end
            if (d_use_rt && (d_rt != 5'd0) && live[k] && (sb_a3[k] == d_rt)) begin
                if (32'(sb_tnew[k]) > 32'(d_tuse_rt)) begin
                    rt_hazard = 1'b1;
                end
                fwd_rt = (sb_tnew[k] == '0) ? FW'(k + 1) : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mult/div busy counter. A start in E already blocks a md instruction
    // in D even though the counter only loads on the following edge.
    // ------------------------------------------------------------------
    assign md_start_vld = (e_md_start == 2'b01) || (e_md_start == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (e_md_start == 2'b01) begin
            md_cnt <= CW'(MUL_LAT);
        end else if (e_md_start == 2'b10) begin
            md_cnt <= CW'(DIV_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_busy   = (md_cnt != '0);
    assign md_hazard = d_md && (md_busy || md_start_vld);
    assign stall     = rs_hazard || rt_hazard || md_hazard;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed self-checking bench for hazard_ctrl (default build plus a NSTAGE=4 build).
// Latency : outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: n/a (bench drives the D stage directly).
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_a3;
    logic       d_regwrite;
    logic [2:0] d_tnew;
    logic       d_md;
    logic [1:0] e_md_start;

    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       md_busy;

    logic       stall4;
    logic [2:0] fwd_rs4;
    logic [2:0] fwd_rt4;
    logic       md_busy4;

    int errors = 0;
    int checks = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .d_tnew     (d_tnew),
        .d_md       (d_md),
        .e_md_start (e_md_start),
        .stall      (stall),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .md_busy    (md_busy)
    );

    hazard_ctrl #(.NSTAGE(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .d_tnew     (d_tnew),
        .d_md       (d_md),
        .e_md_start (e_md_start),
        .stall      (stall4),
        .fwd_rs     (fwd_rs4),
        .fwd_rt     (fwd_rt4),
        .md_busy    (md_busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic       use_rs;
        logic [1:0] tuse_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic [1:0] tuse_rt;
        logic [4:0] a3;
        logic       rw;
        logic [2:0] tnew;
        logic       md;
        logic [1:0] start;
        logic       x_stall;
        logic [1:0] x_frs;
        logic [1:0] x_frt;
        logic       x_busy;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        d_rs = 0; d_use_rs = 0; d_tuse_rs = 0;
        d_rt = 0; d_use_rt = 0; d_tuse_rt = 0;
        d_a3 = 0; d_regwrite = 0; d_tnew = 0;
        d_md = 0; e_md_start = 0;
    endtask

    task automatic apply(input vec_t v);
        d_rs = v.rs; d_use_rs = v.use_rs; d_tuse_rs = v.tuse_rs;
        d_rt = v.rt; d_use_rt = v.use_rt; d_tuse_rt = v.tuse_rt;
        d_a3 = v.a3; d_regwrite = v.rw; d_tnew = v.tnew;
        d_md = v.md; e_md_start = v.start;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Start the md unit while a md instruction sits in D; count stall cycles.
    task automatic run_md(input logic [1:0] code, input int exp_n, input string nm);
        int n;
        idle();
        d_md = 1'b1;
        e_md_start = code;
        @(negedge clk);
        check({nm, "_start_stall"}, stall, 1);
        check({nm, "_busy_pre"}, md_busy, 0);
        n = 1;
        next_cycle();
        e_md_start = 2'b00;
        @(negedge clk);
        check({nm, "_busy_latency"}, md_busy, 1);
        for (int i = 0; i < 40 && stall; i++) begin
            n++;
            next_cycle();
            @(negedge clk);
        end
        check({nm, "_stall_cycles"}, n, exp_n);
        check({nm, "_busy_end"}, md_busy, 0);
        idle();
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        //              rs use tu  rt use tu  a3 rw tn  md st   stall frs frt busy
        vecs[0]  = '{ 0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0};
        vecs[1]  = '{ 0, 0, 0,   0, 0, 0,   8, 1, 2,  0, 0,  0, 0, 0, 0}; // lw $8
        vecs[2]  = '{ 8, 1, 1,   0, 0, 0,   0, 0, 0,  0, 0,  1, 0, 0, 0}; // load-use stall
        vecs[3]  = '{ 8, 1, 1,   0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0}; // lw in M, tnew=1
        vecs[4]  = '{ 8, 1, 0,   8, 1, 2,   0, 0, 0,  0, 0,  0, 3, 3, 0}; // lw in W
        vecs[5]  = '{ 8, 1, 0,   0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0}; // lw retired
        vecs[6]  = '{ 0, 0, 0,   0, 0, 0,   9, 1, 1,  0, 0,  0, 0, 0, 0}; // addu $9
        vecs[7]  = '{ 9, 1, 0,   0, 0, 0,   0, 0, 0,  0, 0,  1, 0, 0, 0}; // beq tuse=0
        vecs[8]  = '{ 9, 1, 0,   0, 0, 0,   0, 0, 0,  0, 0,  0, 2, 0, 0};
        vecs[9]  = '{ 0, 0, 0,   9, 1, 1,  10, 1, 1,  0, 0,  0, 0, 3, 0}; // addu $10
        vecs[10] = '{10, 1, 1,   0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0}; // tuse=1, no stall
        vecs[11] = '{10, 1, 0,   0, 0, 0,   0, 0, 0,  0, 0,  0, 2, 0, 0};
        vecs[12] = '{ 0, 0, 0,  10, 1, 0,   0, 1, 0,  0, 0,  0, 0, 3, 0}; // write $0
        vecs[13] = '{ 0, 1, 0,   0, 1, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0}; // read $0
        vecs[14] = '{ 0, 0, 0,   0, 0, 0,  11, 1, 0,  0, 0,  0, 0, 0, 0}; // $11 ready
        vecs[15] = '{ 0, 0, 0,   0, 0, 0,  11, 1, 2,  0, 0,  0, 0, 0, 0}; // $11 again, slow
        vecs[16] = '{11, 1, 2,  11, 1, 1,   0, 0, 0,  0, 0,  1, 0, 0, 0}; // younger hides older
        vecs[17] = '{11, 1, 2,  11, 1, 1,   0, 0, 0,  0, 0,  0, 0, 0, 0};
        vecs[18] = '{11, 0, 0,  11, 1, 0,   0, 0, 0,  0, 0,  0, 0, 3, 0}; // rs unused

        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_fwd_rs", fwd_rs, 0);
        check("rst_fwd_rt", fwd_rt, 0);
        check("rst_md_busy", md_busy, 0);
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_stall", i), stall, vecs[i].x_stall);
            check($sformatf("v%0d_fwd_rs", i), fwd_rs, vecs[i].x_frs);
            check($sformatf("v%0d_fwd_rt", i), fwd_rt, vecs[i].x_frt);
            check($sformatf("v%0d_md_busy", i), md_busy, vecs[i].x_busy);
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();

        run_md(2'b01, 6, "mult");
        run_md(2'b10, 11, "div");

        // Div start, then a mult start three cycles later overrides it.
        e_md_start = 2'b10;
        next_cycle();
        e_md_start = 2'b00;
        next_cycle();
        next_cycle();
        e_md_start = 2'b01;
        @(negedge clk);
        check("reload_busy_before", md_busy, 1);
        next_cycle();
        e_md_start = 2'b00;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 40 && md_busy; i++) begin
            n++;
            next_cycle();
            @(negedge clk);
        end
        check("reload_busy_cycles", n, 5);
        next_cycle();

        // Reset while a register hazard and a div are both pending.
        d_a3 = 5'd12; d_regwrite = 1'b1; d_tnew = 3'd2; e_md_start = 2'b10;
        next_cycle();
        idle();
        d_rs = 5'd12; d_use_rs = 1'b1;
        @(negedge clk);
        check("prerst_stall", stall, 1);
        check("prerst_busy", md_busy, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        d_md = 1'b1;
        @(negedge clk);
        check("midrst_stall", stall, 0);
        check("midrst_busy", md_busy, 0);
        check("midrst_fwd_rs", fwd_rs, 0);
        idle();
        repeat (5) next_cycle();

        // Deeper pipeline: $5 with tnew=3 read at tuse=0.
        d_a3 = 5'd5; d_regwrite = 1'b1; d_tnew = 3'd3;
        next_cycle();
        idle();
        d_rs = 5'd5; d_use_rs = 1'b1;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20 && stall4; i++) begin
            n++;
            next_cycle();
            @(negedge clk);
        end
        check("n4_stall_cycles", n, 3);
        check("n4_fwd_rs", fwd_rs4, 4);
        check("n4_fwd_rt", fwd_rt4, 0);
        check("n3_dropped_fwd_rs", fwd_rs, 0);
        check("n3_dropped_stall", stall, 0);
        idle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
